// File: rtl/binario_bcd_enc.sv
// Registered binary-to-BCD converter (double-dabble), one conversion per cycle, 1-cycle latency.
// Optional per-digit 7-segment output is built when BINARIO_BCD_SEG7_EN is defined.
module binario_bcd_enc #(
   parameter int BIN_W  = 4,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [BIN_W-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  out_valid
`ifdef BINARIO_BCD_SEG7_EN
   ,
   output logic [7*DIGITS-1:0]   seg
`endif
);

   localparam int BCD_W = 4 * DIGITS;

   // True when DIGITS decimal digits can represent every BIN_W-bit value.
   function automatic bit width_fits();
      longint p10;
      longint p2;
      p10 = 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (p10 < 64'sd1_000_000_000_000_000) p10 = p10 * 10;
      end
      p2 = (BIN_W >= 62) ? 64'sh4000_0000_0000_0000 : (64'sd1 <<< BIN_W);
      return (p10 >= p2);
   endfunction

   generate
      if (!width_fits()) begin : g_width_err
         $error("binario_bcd_enc: 10**DIGITS must be >= 2**BIN_W");
      end
   endgenerate

   logic [BCD_W-1:0] conv;

   // Shift each bit in MSB first; the add-3 pass is skipped after the final shift.
   always_comb begin
      conv = '0;
      for (int b = BIN_W - 1; b >= 0; b--) begin
         conv = {conv[BCD_W-2:0], bin[b]};
         if (b != 0) begin
            for (int d = 0; d < DIGITS; d++) begin
               if (conv[4*d +: 4] > 4'd4) begin
                  conv[4*d +: 4] = conv[4*d +: 4] + 4'd3;
               end
            end
         end
      end
   end

   logic [BCD_W-1:0] bcd_q;
   logic [BCD_W-1:0] bcd_d;
   logic             valid_q;
   logic             valid_d;

   always_comb begin
      bcd_d   = bcd_q;
      valid_d = in_valid;
      if (in_valid) begin
         bcd_d = conv;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         bcd_q   <= bcd_d;
         valid_q <= valid_d;
      end
   end

   assign bcd       = bcd_q;
   assign out_valid = valid_q;

`ifdef BINARIO_BCD_SEG7_EN
   // Segment order {g,f,e,d,c,b,a}; non-decimal nibbles blank the digit.
   function automatic logic [6:0] seg_of(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   logic [7*DIGITS-1:0] seg_q;
   logic [7*DIGITS-1:0] seg_d;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_seg
         always_comb begin
            seg_d[7*gi +: 7] = seg_q[7*gi +: 7];
            if (in_valid) begin
               seg_d[7*gi +: 7] = seg_of(conv[4*gi +: 4]);
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= '0;
      end else begin
         seg_q <= seg_d;
      end
   end

   assign seg = seg_q;
`endif

endmodule

// File: tb/tb_binario_bcd_enc.sv
// Scoreboard bench for binario_bcd_enc: driver pushes expected BCD, a forked monitor pops on out_valid.
module tb_binario_bcd_enc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] bin;
   logic [7:0] bcd;
   logic       out_valid;
`ifdef BINARIO_BCD_SEG7_EN
   logic [13:0] seg;
`endif

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   binario_bcd_enc #(.BIN_W(4), .DIGITS(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .bin       (bin),
      .bcd       (bcd),
      .out_valid (out_valid)
`ifdef BINARIO_BCD_SEG7_EN
      ,
      .seg       (seg)
`endif
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end else begin
         $display("ok   %s: got=%h", name, act);
      end
   endtask

`ifdef BINARIO_BCD_SEG7_EN
   function automatic logic [6:0] seg_ref(input logic [3:0] n);
      logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return (n < 10) ? t[n] : 7'h00;
   endfunction
`endif

   // Drive at the falling edge; expected value enters the scoreboard when a capture is requested.
   task automatic drive(input logic v, input logic [3:0] b, input logic [7:0] e);
      @(negedge clk);
      in_valid = v;
      bin      = b;
      if (v && rst_n) exp_q.push_back(e);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Hand-computed BCD images of 0..15.
      logic [7:0] sweep_exp [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                     8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      rst_n    = 1'b0;
      in_valid = 1'b1;
      bin      = 4'd9;

      fork
         forever begin
            @(posedge clk);
            #1;
            if (rst_n && out_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out_valid", 16'(out_valid), 16'h0);
               end else begin
                  logic [7:0] e;
                  e = exp_q.pop_front();
                  check("bcd", 16'(bcd), 16'(e));
`ifdef BINARIO_BCD_SEG7_EN
                  check("seg", 16'(seg), 16'({seg_ref(e[7:4]), seg_ref(e[3:0])}));
`endif
               end
            end
         end
      join_none

      // Reset held with a live capture request.
      for (int i = 0; i < 3; i++) begin
         after_edge();
         check("reset_bcd", 16'(bcd), 16'h00);
         check("reset_out_valid", 16'(out_valid), 16'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(8'h09);
      #1;
      check("release_bcd", 16'(bcd), 16'h00);
      check("release_out_valid", 16'(out_valid), 16'h0);

      // Sweep 0..15 back-to-back.
      for (int v = 0; v < 16; v++) drive(1'b1, 4'(v), sweep_exp[v]);

      // Decade edge.
      drive(1'b1, 4'd9, 8'h09);
      drive(1'b1, 4'd10, 8'h10);

`ifdef BINARIO_BCD_SEG7_EN
      drive(1'b1, 4'd8, 8'h08);
      after_edge();
      check("seg8_d0", 16'(seg[6:0]), 16'h7F);
      check("seg8_d1", 16'(seg[13:7]), 16'h3F);
      drive(1'b1, 4'd1, 8'h01);
      after_edge();
      check("seg1_d0", 16'(seg[6:0]), 16'h06);
`endif

      // Hold: value stays, out_valid drops.
      drive(1'b1, 4'd13, 8'h13);
      drive(1'b0, 4'd4, 8'h00);
      after_edge();
      check("hold_bcd", 16'(bcd), 16'h13);
      check("hold_out_valid", 16'(out_valid), 16'h0);

      // Asynchronous reset while bcd=0x15.
      drive(1'b1, 4'd15, 8'h15);
      drive(1'b0, 4'd0, 8'h00);
      after_edge();
      check("pre_reset_bcd", 16'(bcd), 16'h15);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_bcd", 16'(bcd), 16'h00);
      check("async_reset_out_valid", 16'(out_valid), 16'h0);
`ifdef BINARIO_BCD_SEG7_EN
      check("async_reset_seg", 16'(seg), 16'h0);
`endif
      #1;
      rst_n = 1'b1;

      // Cold start after reset.
      drive(1'b1, 4'd7, 8'h07);
      drive(1'b0, 4'd0, 8'h00);

      // Bounded drain of the scoreboard.
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      check("scoreboard_empty", 16'(exp_q.size()), 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
